// File: rtl/memory_controller_q_if.sv
// Request/response bus between a requester and memory_controller_q.
// master = requester side, slave = controller side.
interface memory_controller_q_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic [ADDR_W-1:0] wr_ret_address;
  logic              wr_ret_ack;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_address;
  logic              rd_full;
  logic [DATA_W-1:0] rd_ret_data;
  logic [ADDR_W-1:0] rd_ret_address;
  logic              rd_ret_ack;

  modport master (
    output wr_en, wr_address, wr_data, rd_en, rd_address,
    input  wr_full, wr_ret_address, wr_ret_ack,
    input  rd_full, rd_ret_data, rd_ret_address, rd_ret_ack
  );

  modport slave (
    input  wr_en, wr_address, wr_data, rd_en, rd_address,
    output wr_full, wr_ret_address, wr_ret_ack,
    output rd_full, rd_ret_data, rd_ret_address, rd_ret_ack
  );
endinterface

// File: rtl/memory_controller_q.sv
// Queued single-port memory controller: read/write request FIFOs, round-robin
// arbitration with read-after-write protection, fixed-latency memory pipeline.
module memory_controller_q #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int Q_DEPTH = 4,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  memory_controller_q_if.slave bus
);
  localparam int MW = $clog2(DEPTH);
  localparam int IW = $clog2(Q_DEPTH);
  localparam int PW = IW + 1;

  localparam logic [0:0] S_RD_PRI = 1'b0;
  localparam logic [0:0] S_WR_PRI = 1'b1;

  // Request FIFOs
  logic [ADDR_W-1:0] wq_addr [Q_DEPTH];
  logic [DATA_W-1:0] wq_data [Q_DEPTH];
  logic [ADDR_W-1:0] rq_addr [Q_DEPTH];
  logic [PW-1:0]     w_wptr, w_rptr, w_count, w_count_next;
  logic [PW-1:0]     r_wptr, r_rptr, r_count, r_count_next;
  logic              wr_full_q, rd_full_q;
  logic              w_push, r_push;

  // Arbitration
  logic [0:0]        arb_state, arb_next;
  logic              issue_wr, issue_rd, raw_hazard;
  logic [ADDR_W-1:0] w_head_addr, r_head_addr, iss_addr;
  logic [DATA_W-1:0] w_head_data;

  // Memory and pipeline
  logic [DATA_W-1:0] mem [DEPTH];
  logic              p_valid [LATENCY];
  logic              p_rd    [LATENCY];
  logic [ADDR_W-1:0] p_addr  [LATENCY];
  logic [DATA_W-1:0] p_data  [LATENCY];

  // Response registers
  logic              wr_ack_q, rd_ack_q;
  logic [ADDR_W-1:0] wr_ret_addr_q, rd_ret_addr_q;
  logic [DATA_W-1:0] rd_ret_data_q;

  // full is sampled before any pop this cycle, so a push onto a full FIFO is dropped
  assign w_push = bus.wr_en && !wr_full_q;
  assign r_push = bus.rd_en && !rd_full_q;

  assign w_head_addr = wq_addr[w_rptr[IW-1:0]];
  assign w_head_data = wq_data[w_rptr[IW-1:0]];
  assign r_head_addr = rq_addr[r_rptr[IW-1:0]];
  assign iss_addr    = issue_rd ? r_head_addr : w_head_addr;

  assign w_count_next = w_count + PW'(w_push) - PW'(issue_wr);
  assign r_count_next = r_count + PW'(r_push) - PW'(issue_rd);

  // Read head collides with any queued write to the same word
  always_comb begin
    logic [IW-1:0] slot;
    slot       = '0;
    raw_hazard = 1'b0;
    for (int unsigned i = 0; i < Q_DEPTH; i++) begin
      slot = w_rptr[IW-1:0] + IW'(i);
      if ((PW'(i) < w_count) && (wq_addr[slot][MW-1:0] == r_head_addr[MW-1:0]))
        raw_hazard = 1'b1;
    end
  end

  // Pick at most one FIFO head; counts are pre-push so a fresh entry waits a cycle
  always_comb begin
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    arb_next = arb_state;
    if ((r_count != '0) && (w_count != '0)) begin
      if (raw_hazard) begin
        issue_wr = 1'b1;
      end else if (arb_state == S_RD_PRI) begin
        issue_rd = 1'b1;
        arb_next = S_WR_PRI;
      end else begin
        issue_wr = 1'b1;
        arb_next = S_RD_PRI;
      end
    end else if (r_count != '0) begin
      issue_rd = 1'b1;
    end else if (w_count != '0) begin
      issue_wr = 1'b1;
    end
  end

  // FIFO pointers, counts, registered full flags and arbiter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_wptr    <= '0;
      w_rptr    <= '0;
      w_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      wr_full_q <= 1'b0;
      rd_full_q <= 1'b0;
      arb_state <= S_RD_PRI;
    end else begin
      if (w_push)   w_wptr <= w_wptr + 1'b1;
      if (issue_wr) w_rptr <= w_rptr + 1'b1;
      if (r_push)   r_wptr <= r_wptr + 1'b1;
      if (issue_rd) r_rptr <= r_rptr + 1'b1;
      w_count   <= w_count_next;
      r_count   <= r_count_next;
      wr_full_q <= (w_count_next == PW'(Q_DEPTH));
      rd_full_q <= (r_count_next == PW'(Q_DEPTH));
      arb_state <= arb_next;
    end
  end

  // Unreset storage: FIFO slots, memory array, pipeline data
  always_ff @(posedge clk) begin
    if (w_push) begin
      wq_addr[w_wptr[IW-1:0]] <= bus.wr_address;
      wq_data[w_wptr[IW-1:0]] <= bus.wr_data;
    end
    if (r_push)
      rq_addr[r_wptr[IW-1:0]] <= bus.rd_address;
    if (issue_wr)
      mem[w_head_addr[MW-1:0]] <= w_head_data;
    p_data[0] <= issue_rd ? mem[r_head_addr[MW-1:0]] : w_head_data;
    for (int unsigned i = 1; i < LATENCY; i++)
      p_data[i] <= p_data[i-1];
  end

  // Pipeline control: issued op advances one stage per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        p_valid[i] <= 1'b0;
        p_rd[i]    <= 1'b0;
        p_addr[i]  <= '0;
      end
    end else begin
      p_valid[0] <= issue_rd || issue_wr;
      p_rd[0]    <= issue_rd;
      p_addr[0]  <= iss_addr;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_rd[i]    <= p_rd[i-1];
        p_addr[i]  <= p_addr[i-1];
      end
    end
  end

  // Response registers: one-cycle ack, payload held between acks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      wr_ret_addr_q <= '0;
      rd_ret_addr_q <= '0;
      rd_ret_data_q <= '0;
    end else begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      if (p_valid[LATENCY-1]) begin
        if (p_rd[LATENCY-1]) begin
          rd_ack_q      <= 1'b1;
          rd_ret_addr_q <= p_addr[LATENCY-1];
          rd_ret_data_q <= p_data[LATENCY-1];
        end else begin
          wr_ack_q      <= 1'b1;
          wr_ret_addr_q <= p_addr[LATENCY-1];
        end
      end
    end
  end

  assign bus.wr_full        = wr_full_q;
  assign bus.rd_full        = rd_full_q;
  assign bus.wr_ret_ack     = wr_ack_q;
  assign bus.wr_ret_address = wr_ret_addr_q;
  assign bus.rd_ret_ack     = rd_ack_q;
  assign bus.rd_ret_address = rd_ret_addr_q;
  assign bus.rd_ret_data    = rd_ret_data_q;
endmodule

// File: tb/tb_memory_controller_q.sv
// Scoreboard bench for memory_controller_q.
module tb_memory_controller_q;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 256;
  localparam int Q_DEPTH = 4;
  localparam int LATENCY = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  memory_controller_q_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory_controller_q #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .Q_DEPTH(Q_DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [ADDR_W-1:0] wr_exp   [$];
  logic [ADDR_W-1:0] rd_exp_a [$];
  logic [DATA_W-1:0] rd_exp_d [$];
  bit                ack_seq  [$];
  bit                log_on = 1'b0;
  int unsigned       wr_ack_cnt = 0;
  int unsigned       rd_ack_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding request of its channel
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_ret_ack) begin
        wr_ack_cnt++;
        if (log_on) ack_seq.push_back(1'b0);
        if (wr_exp.size() == 0) check_eq("wr_unexpected_ack", 32'(bus.wr_ret_ack), 32'd0);
        else check_eq("wr_ret_address", 32'(bus.wr_ret_address), 32'(wr_exp.pop_front()));
      end
      if (bus.rd_ret_ack) begin
        rd_ack_cnt++;
        if (log_on) ack_seq.push_back(1'b1);
        if (rd_exp_a.size() == 0) check_eq("rd_unexpected_ack", 32'(bus.rd_ret_ack), 32'd0);
        else begin
          check_eq("rd_ret_address", 32'(bus.rd_ret_address), 32'(rd_exp_a.pop_front()));
          check_eq("rd_ret_data", 32'(bus.rd_ret_data), 32'(rd_exp_d.pop_front()));
        end
      end
    end
  end

  task automatic set_idle();
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.wr_address = '0;
    bus.wr_data    = '0;
    bus.rd_address = '0;
  endtask

  // Drive one request cycle; acceptance judged from the registered full flags
  task automatic drive_cycle(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                             input bit re, input logic [ADDR_W-1:0] ra,
                             output bit w_acc, output bit r_acc);
    @(negedge clk);
    bus.wr_en      = we;
    bus.wr_address = wa;
    bus.wr_data    = wd;
    bus.rd_en      = re;
    bus.rd_address = ra;
    w_acc = we && !bus.wr_full;
    r_acc = re && !bus.rd_full;
    if (w_acc) begin
      model[wa % DEPTH] = wd;
      wr_exp.push_back(wa);
    end
    if (r_acc) begin
      rd_exp_a.push_back(ra);
      rd_exp_d.push_back(model[ra % DEPTH]);
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    @(negedge clk);
    set_idle();
    while ((wr_exp.size() != 0 || rd_exp_a.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq("drain_outstanding", 32'(wr_exp.size() + rd_exp_a.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wa, ra;
    int unsigned cyc, w_pre, r_pre, w_drop, wacc_tot, wack0, ack0, same, wi, ri;
    bit w_seen, r_seen;

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    set_idle();
    repeat (3) @(negedge clk);
    check_eq("rst_flags", {28'd0, bus.wr_full, bus.rd_full, bus.wr_ret_ack, bus.rd_ret_ack}, 32'd0);
    check_eq("rst_wr_addr", 32'(bus.wr_ret_address), 32'd0);
    check_eq("rst_rd_addr", 32'(bus.rd_ret_address), 32'd0);
    check_eq("rst_rd_data", 32'(bus.rd_ret_data), 32'd0);
    reset = 1'b0;

    // 1: single write then read; accept edge N, ack seen at the negedge after edge N+1+LATENCY
    drive_cycle(1'b1, 16'd5, 16'hABCD, 1'b0, '0, wa, ra);
    @(negedge clk); set_idle(); cyc = 1;
    while (!bus.wr_ret_ack && cyc < 40) begin @(negedge clk); cyc++; end
    check_eq("t1_wr_latency", cyc, LATENCY + 2);
    drain();
    drive_cycle(1'b0, '0, '0, 1'b1, 16'd5, wa, ra);
    @(negedge clk); set_idle(); cyc = 1;
    while (!bus.rd_ret_ack && cyc < 40) begin @(negedge clk); cyc++; end
    check_eq("t1_rd_latency", cyc, LATENCY + 2);
    drain();

    // 5: address aliasing
    drive_cycle(1'b1, 16'd3, 16'h0055, 1'b0, '0, wa, ra);
    drain();
    drive_cycle(1'b0, '0, '0, 1'b1, 16'(DEPTH + 3), wa, ra);
    drain();
    check_eq("t5_rd_addr_hold", 32'(bus.rd_ret_address), 32'(DEPTH + 3));
    check_eq("t5_rd_data_hold", 32'(bus.rd_ret_data), 32'h55);

    // 2: both channels pushed every cycle; arbiter is in read-priority, so the
    //    write FIFO reaches full after 2*Q_DEPTH-2 pushes and the read FIFO after 2*Q_DEPTH-1
    w_pre = 0; r_pre = 0; w_drop = 0; wacc_tot = 0; w_seen = 0; r_seen = 0;
    wack0 = wr_ack_cnt;
    for (int i = 0; i < 14; i++) begin
      drive_cycle(1'b1, 16'(20 + i), 16'(16'h2000 + i), 1'b1, 16'(40 + i), wa, ra);
      if (wa) wacc_tot++; else w_drop++;
      if (!w_seen) begin if (wa) w_pre++; else w_seen = 1; end
      if (!r_seen) begin if (ra) r_pre++; else r_seen = 1; end
    end
    drain();
    check_eq("t2_wr_pushes_to_full", w_pre, 2 * Q_DEPTH - 2);
    check_eq("t2_rd_pushes_to_full", r_pre, 2 * Q_DEPTH - 1);
    check_eq("t2_drop_seen", 32'(w_drop != 0), 32'd1);
    check_eq("t2_wr_ack_count", wr_ack_cnt - wack0, wacc_tot);

    // 3: same-cycle write/read of one word; reads must see the new value
    drive_cycle(1'b1, 16'd150, 16'h1111, 1'b0, '0, wa, ra);
    drain();
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b1, 16'd150, 16'd7, 1'b1, 16'd150, wa, ra);
    drain();
    check_eq("t3_last_rd_data", 32'(bus.rd_ret_data), 32'd7);

    // 4: concurrent streams with retry on full; issues must alternate channels
    ack_seq.delete();
    log_on = 1'b1;
    wi = 0; ri = 0; cyc = 0;
    while ((wi < 10 || ri < 10) && cyc < 200) begin
      drive_cycle(wi < 10, 16'(100 + wi), 16'(16'h4000 + wi), ri < 10, 16'(ri), wa, ra);
      if (wa) wi++;
      if (ra) ri++;
      cyc++;
    end
    drain();
    log_on = 1'b0;
    check_eq("t4_ack_total", ack_seq.size(), 32'd20);
    same = 0;
    for (int i = 1; i < ack_seq.size(); i++)
      if (ack_seq[i] == ack_seq[i-1]) same++;
    check_eq("t4_same_channel_runs", same, 32'd0);

    // 6: reset with work in flight
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 16'(200 + i), 16'(16'h6000 + i), 1'b1, 16'(210 + i), wa, ra);
    @(negedge clk); set_idle();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_eq("t6_rst_flags", {28'd0, bus.wr_full, bus.rd_full, bus.wr_ret_ack, bus.rd_ret_ack}, 32'd0);
    check_eq("t6_rst_wr_addr", 32'(bus.wr_ret_address), 32'd0);
    check_eq("t6_rst_rd_addr", 32'(bus.rd_ret_address), 32'd0);
    check_eq("t6_rst_rd_data", 32'(bus.rd_ret_data), 32'd0);
    wr_exp.delete(); rd_exp_a.delete(); rd_exp_d.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ack0 = wr_ack_cnt + rd_ack_cnt;
    repeat (20) @(negedge clk);
    check_eq("t6_acks_after_reset", wr_ack_cnt + rd_ack_cnt - ack0, 32'd0);
    drive_cycle(1'b1, 16'd9, 16'h0077, 1'b0, '0, wa, ra);
    drive_cycle(1'b0, '0, '0, 1'b1, 16'd9, wa, ra);
    drain();
    check_eq("t6_new_rd_data", 32'(bus.rd_ret_data), 32'h77);
    check_eq("t6_new_rd_addr", 32'(bus.rd_ret_address), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
